// File: rtl/ibm_pkt_buffer_if.sv
// Buffer-manager bus: packet writes from pac, descriptors to the scheduler,
// ID releases and slot readout from the scheduler, idle-ID count back upstream.
interface ibm_pkt_buffer_if;
  logic [133:0] in_ibm_data;
  logic         in_ibm_data_wr;
  logic         in_ibm_valid;
  logic         in_ibm_valid_wr;
  logic [23:0]  in_ibm_tsn_md;
  logic         in_ibm_tsn_md_wr;
  logic [4:0]   bufm_ID_count;
  logic [35:0]  out_ibm_desc;
  logic         out_ibm_desc_wr;
  logic [3:0]   in_ibm_id_free;
  logic         in_ibm_id_free_wr;
  logic [10:0]  in_ibm_rd_addr;
  logic         in_ibm_rd_en;
  logic [133:0] out_ibm_rd_data;
  logic         out_ibm_rd_data_valid;
  logic [31:0]  ibm_drop_cnt;

  modport master (
    output in_ibm_data, in_ibm_data_wr, in_ibm_valid, in_ibm_valid_wr,
           in_ibm_tsn_md, in_ibm_tsn_md_wr, in_ibm_id_free, in_ibm_id_free_wr,
           in_ibm_rd_addr, in_ibm_rd_en,
    input  bufm_ID_count, out_ibm_desc, out_ibm_desc_wr, out_ibm_rd_data,
           out_ibm_rd_data_valid, ibm_drop_cnt
  );

  modport slave (
    input  in_ibm_data, in_ibm_data_wr, in_ibm_valid, in_ibm_valid_wr,
           in_ibm_tsn_md, in_ibm_tsn_md_wr, in_ibm_id_free, in_ibm_id_free_wr,
           in_ibm_rd_addr, in_ibm_rd_en,
    output bufm_ID_count, out_ibm_desc, out_ibm_desc_wr, out_ibm_rd_data,
           out_ibm_rd_data_valid, ibm_drop_cnt
  );
endinterface

// File: rtl/ibm_pkt_buffer.sv
// Input buffer manager: stores admitted packets into per-ID slots taken from a
// free-ID FIFO, emits {tsn_md, id, len} descriptors and serves slot readout.
module ibm_pkt_buffer #(
  parameter int ID_NUM = 16,
  parameter int ID_W   = 4,
  parameter int WORD_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  ibm_pkt_buffer_if.slave bus
);
  localparam int ADDR_W = ID_W + WORD_W;
  localparam int CNT_W  = ID_W + 1;
  localparam int LEN_W  = WORD_W + 1;
  localparam int DATA_W = 134;
  localparam int MD_W   = 24;
  localparam int DESC_W = MD_W + ID_W + LEN_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ID_NUM);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      cur_id_q;
  logic [WORD_W-1:0]    wptr_q;
  logic [MD_W-1:0]      md_q;
  logic [DESC_W-1:0]    desc_q;
  logic                 desc_wr_q;
  logic [31:0]          drop_cnt_q;

  logic [ID_W-1:0]      fifo_q [ID_NUM];
  logic [ID_W-1:0]      frptr_q, fwptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [ID_W-1:0]      pend_id_q, pend_id_d;

  logic [DATA_W-1:0]    mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]    rd_data_q;
  logic                 rd_vld_q;

  logic                 is_head, have_id, start;
  logic                 pop_en, ret_en, ram_we, desc_en;
  logic                 drop_abort, drop_head;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [ID_W-1:0]      pop_id, push_id;
  logic                 push_ext, push_en, ret_held;
  logic [LEN_W-1:0]     len;

  assign is_head = bus.in_ibm_data_wr && (bus.in_ibm_data[133:132] == 2'b01);
  assign have_id = (count_q != '0);
  assign pop_id  = fifo_q[frptr_q];
  // The tail word sits at wptr_q, so the packet length is wptr_q + 1 (1..128).
  assign len     = LEN_W'(wptr_q) + LEN_W'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    pop_en     = 1'b0;
    ret_en     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = {cur_id_q, wptr_q};
    desc_en    = 1'b0;
    drop_abort = 1'b0;
    drop_head  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (is_head) start = 1'b1;
      end
      WRITE: begin
        if (is_head) begin
          ret_en     = 1'b1;
          drop_abort = 1'b1;
          start      = 1'b1;
        end else if (bus.in_ibm_data_wr && (wptr_q == '0)) begin
          // wptr wrapped: this is word 129, which does not fit the slot.
          ret_en     = 1'b1;
          drop_abort = 1'b1;
          state_d    = bus.in_ibm_valid_wr ? IDLE : DROP;
        end else begin
          ram_we = bus.in_ibm_data_wr;
          if (bus.in_ibm_valid_wr) begin
            state_d = IDLE;
            desc_en = bus.in_ibm_valid;
            ret_en  = !bus.in_ibm_valid;
          end
        end
      end
      DROP: begin
        if (bus.in_ibm_valid_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      if (have_id) begin
        pop_en    = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = {pop_id, {WORD_W{1'b0}}};
        state_d   = WRITE;
      end else begin
        drop_head = 1'b1;
        state_d   = bus.in_ibm_valid_wr ? IDLE : DROP;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      wptr_q     <= '0;
      md_q       <= '0;
      desc_q     <= '0;
      desc_wr_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      desc_wr_q  <= desc_en;
      drop_cnt_q <= drop_cnt_q + 32'(drop_abort) + 32'(drop_head);
      if (desc_en) desc_q <= {md_q, cur_id_q, len};
      if (pop_en) begin
        cur_id_q <= pop_id;
        wptr_q   <= WORD_W'(1);
        md_q     <= bus.in_ibm_tsn_md_wr ? bus.in_ibm_tsn_md : '0;
      end else if (ram_we) begin
        wptr_q   <= wptr_q + WORD_W'(1);
      end
    end
  end

  // External release wins the single push port; an internal return that loses
  // waits one cycle in the pending register.
  assign push_ext   = bus.in_ibm_id_free_wr && (count_q != FULL_CNT);
  assign push_en    = push_ext || pend_vld_q || ret_en;
  assign push_id    = push_ext   ? bus.in_ibm_id_free :
                      pend_vld_q ? pend_id_q : cur_id_q;
  assign ret_held   = ret_en && (push_ext || pend_vld_q);
  assign pend_vld_d = ret_held || (pend_vld_q && push_ext);
  assign pend_id_d  = ret_held ? cur_id_q : pend_id_q;
  assign count_d    = count_q + CNT_W'(push_en) - CNT_W'(pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ID_NUM; i++) fifo_q[i] <= ID_W'(i);
      frptr_q    <= '0;
      fwptr_q    <= '0;
      count_q    <= FULL_CNT;
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
    end else begin
      if (push_en) begin
        fifo_q[fwptr_q] <= push_id;
        fwptr_q         <= fwptr_q + ID_W'(1);
      end
      if (pop_en) frptr_q <= frptr_q + ID_W'(1);
      count_q    <= count_d;
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
    end
  end

  // NOTE: the packet RAM has no reset; every word is written before it is read.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= bus.in_ibm_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= bus.in_ibm_rd_en;
      if (bus.in_ibm_rd_en) rd_data_q <= mem_q[bus.in_ibm_rd_addr];
    end
  end

  assign bus.bufm_ID_count         = count_q;
  assign bus.out_ibm_desc          = desc_q;
  assign bus.out_ibm_desc_wr       = desc_wr_q;
  assign bus.out_ibm_rd_data       = rd_data_q;
  assign bus.out_ibm_rd_data_valid = rd_vld_q;
  assign bus.ibm_drop_cnt          = drop_cnt_q;
endmodule

// File: tb/tb_ibm_pkt_buffer.sv
// Directed bench for ibm_pkt_buffer: a packet table plus hand-written sequences
// for overflow, release collisions, mid-packet heads and mid-packet reset.
module tb_ibm_pkt_buffer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ibm_pkt_buffer_if bus();
  ibm_pkt_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          len;
    bit          valid;
    logic [23:0] md;
    bit          exp_desc;
    logic [3:0]  exp_id;
    logic [7:0]  exp_len;
    logic [4:0]  exp_count;
    logic [31:0] exp_drop;
  } vec_t;

  vec_t        vecs[16];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          desc_seen = 0;
  logic [35:0] last_desc = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_ibm_desc_wr === 1'b1) begin
      desc_seen++;
      last_desc = bus.out_ibm_desc;
    end
  end

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mk_word(input logic [1:0] t, input int tag, input int idx);
    logic [133:0] w;
    w = '0;
    w[133:132] = t;
    w[63:32]   = tag;
    w[31:0]    = idx;
    return w;
  endfunction

  function automatic logic [1:0] type_of(input int i, input int n);
    if (i == 0) return 2'b01;
    if (i == n - 1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic idle();
    bus.in_ibm_data_wr   = 1'b0;
    bus.in_ibm_valid_wr  = 1'b0;
    bus.in_ibm_valid     = 1'b0;
    bus.in_ibm_tsn_md_wr = 1'b0;
  endtask

  task automatic drive_word(input logic [1:0] t, input int tag, input int idx,
                            input bit vwr, input bit v, input logic [23:0] md);
    bus.in_ibm_data      = mk_word(t, tag, idx);
    bus.in_ibm_data_wr   = 1'b1;
    bus.in_ibm_tsn_md    = md;
    bus.in_ibm_tsn_md_wr = (t == 2'b01);
    bus.in_ibm_valid_wr  = vwr;
    bus.in_ibm_valid     = v;
    tick();
  endtask

  task automatic send_pkt(input int n, input bit v, input logic [23:0] md, input int tag);
    for (int i = 0; i < n; i++) drive_word(type_of(i, n), tag, i, (i == n - 1), v, md);
    idle();
    tick();
  endtask

  task automatic release_id(input logic [3:0] id);
    bus.in_ibm_id_free    = id;
    bus.in_ibm_id_free_wr = 1'b1;
    tick();
    bus.in_ibm_id_free_wr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [10:0] addr, input logic [133:0] exp);
    bus.in_ibm_rd_addr = addr;
    bus.in_ibm_rd_en   = 1'b1;
    tick();
    bus.in_ibm_rd_en   = 1'b0;
    check({name, "_valid"}, bus.out_ibm_rd_data_valid, 1);
    check(name, bus.out_ibm_rd_data, exp);
  endtask

  initial begin
    int ds;
    rst_n = 1'b0;
    bus.in_ibm_data = '0;
    bus.in_ibm_tsn_md = '0;
    bus.in_ibm_id_free = '0;
    bus.in_ibm_id_free_wr = 1'b0;
    bus.in_ibm_rd_addr = '0;
    bus.in_ibm_rd_en = 1'b0;
    idle();

    for (int i = 1; i <= 15; i++)
      vecs[i-1] = '{len: 2 + (i % 4), valid: 1'b1, md: 24'h100000 + 24'(i), exp_desc: 1'b1,
                    exp_id: 4'(i), exp_len: 8'(2 + (i % 4)), exp_count: 5'(15 - i), exp_drop: 32'd0};
    vecs[15] = '{len: 3, valid: 1'b1, md: 24'hFFFFFF, exp_desc: 1'b0,
                 exp_id: 4'd0, exp_len: 8'd0, exp_count: 5'd0, exp_drop: 32'd1};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_count", bus.bufm_ID_count, 16);
    check("rst_desc_wr", bus.out_ibm_desc_wr, 0);
    check("rst_drop", bus.ibm_drop_cnt, 0);
    check("rst_rd_valid", bus.out_ibm_rd_data_valid, 0);

    // First packet, then readback of its slot.
    ds = desc_seen;
    send_pkt(4, 1'b1, 24'hABC123, 1);
    check("p1_desc_cnt", desc_seen - ds, 1);
    check("p1_desc", last_desc, {24'hABC123, 4'h0, 8'd4});
    check("p1_count", bus.bufm_ID_count, 15);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("p1_rd%0d", i), 11'(i), mk_word(type_of(i, 4), 1, i));
    tick();
    check("rd_valid_off", bus.out_ibm_rd_data_valid, 0);

    // IDs 1..15 in order, then a head with no free ID.
    for (int k = 0; k < 16; k++) begin
      ds = desc_seen;
      send_pkt(vecs[k].len, vecs[k].valid, vecs[k].md, 100 + k);
      check($sformatf("tbl%0d_desc_cnt", k), desc_seen - ds, vecs[k].exp_desc);
      if (vecs[k].exp_desc)
        check($sformatf("tbl%0d_desc", k), last_desc, {vecs[k].md, vecs[k].exp_id, vecs[k].exp_len});
      check($sformatf("tbl%0d_count", k), bus.bufm_ID_count, vecs[k].exp_count);
      check($sformatf("tbl%0d_drop", k), bus.ibm_drop_cnt, vecs[k].exp_drop);
    end

    for (int i = 0; i < 5; i++) release_id(4'(i));
    check("rel5_count", bus.bufm_ID_count, 5);

    // valid=0 tail: ID 0 comes back, no drop.
    ds = desc_seen;
    send_pkt(3, 1'b0, 24'h777777, 200);
    check("inval_desc_cnt", desc_seen - ds, 0);
    check("inval_count", bus.bufm_ID_count, 5);
    check("inval_drop", bus.ibm_drop_cnt, 1);

    // 129 words on ID 1: overflow, 129th word must not land in word 0.
    ds = desc_seen;
    send_pkt(129, 1'b1, 24'h222222, 201);
    check("ovf_desc_cnt", desc_seen - ds, 0);
    check("ovf_count", bus.bufm_ID_count, 5);
    check("ovf_drop", bus.ibm_drop_cnt, 2);
    read_check("ovf_word0", {4'd1, 7'd0}, mk_word(2'b01, 201, 0));

    // 128 words on ID 2: full slot.
    ds = desc_seen;
    send_pkt(128, 1'b1, 24'h555555, 202);
    check("max_desc_cnt", desc_seen - ds, 1);
    check("max_desc", last_desc, {24'h555555, 4'd2, 8'd128});
    check("max_count", bus.bufm_ID_count, 4);
    read_check("max_last", {4'd2, 7'd127}, mk_word(2'b10, 202, 127));

    ds = desc_seen;
    send_pkt(2, 1'b1, 24'h0F0F0F, 203);
    check("min_desc", last_desc, {24'h0F0F0F, 4'd3, 8'd2});
    check("min_count", bus.bufm_ID_count, 3);

    // Release of ID 3 collides with the valid=0 return of ID 4.
    ds = desc_seen;
    drive_word(2'b01, 300, 0, 1'b0, 1'b1, 24'h0BEEF0);
    check("coll_head_count", bus.bufm_ID_count, 2);
    bus.in_ibm_id_free    = 4'd3;
    bus.in_ibm_id_free_wr = 1'b1;
    drive_word(2'b10, 300, 1, 1'b1, 1'b0, 24'h0BEEF0);
    bus.in_ibm_id_free_wr = 1'b0;
    idle();
    check("coll_cycle1_count", bus.bufm_ID_count, 3);
    tick();
    check("coll_cycle2_count", bus.bufm_ID_count, 4);
    check("coll_desc_cnt", desc_seen - ds, 0);
    check("coll_drop", bus.ibm_drop_cnt, 2);

    // Fill the pool, then an extra release must be ignored.
    release_id(4'd2);
    for (int i = 5; i < 16; i++) release_id(4'(i));
    check("full_count", bus.bufm_ID_count, 16);
    release_id(4'd7);
    tick();
    check("full_rel_ignored", bus.bufm_ID_count, 16);

    // Head arrives mid-packet: ID 0 aborted, new packet stored under ID 1.
    ds = desc_seen;
    drive_word(2'b01, 400, 0, 1'b0, 1'b1, 24'h999999);
    drive_word(2'b11, 400, 1, 1'b0, 1'b1, 24'h999999);
    drive_word(2'b11, 400, 2, 1'b0, 1'b1, 24'h999999);
    send_pkt(3, 1'b1, 24'h123456, 401);
    check("abort_desc_cnt", desc_seen - ds, 1);
    check("abort_desc", last_desc, {24'h123456, 4'd1, 8'd3});
    check("abort_count", bus.bufm_ID_count, 15);
    check("abort_drop", bus.ibm_drop_cnt, 3);

    // Reset in the middle of a packet.
    ds = desc_seen;
    drive_word(2'b01, 500, 0, 1'b0, 1'b1, 24'h314159);
    drive_word(2'b11, 500, 1, 1'b0, 1'b1, 24'h314159);
    check("prerst_count", bus.bufm_ID_count, 14);
    idle();
    rst_n = 1'b0;
    tick();
    check("midrst_count", bus.bufm_ID_count, 16);
    check("midrst_drop", bus.ibm_drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("midrst_desc_cnt", desc_seen - ds, 0);
    send_pkt(2, 1'b1, 24'hA5A5A5, 600);
    check("postrst_desc", last_desc, {24'hA5A5A5, 4'd0, 8'd2});
    check("postrst_count", bus.bufm_ID_count, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
